alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Multi-cycle control and register stage wrapped around the 8-bit combinational ALU.
- Accepts one command per valid/ready handshake and reads two operands from a 4x8 register file, or one operand plus an immediate.
- Drives the ALU operand and opSel inputs from registers, then captures the ALU result and flags.
- Writes the result back to the register file and holds the flags in a sticky flag register for downstream branch/status logic.

Parameters:
- DATA_W, 8, operand/result width; must match the ALU.
- NREGS, 4, register file depth; address width is log2(NREGS).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command this cycle.
- cmd_op  input  3  ALU opSel code: 0 add, 1 sub, 2 and, 3 or, 4 pass a, 5 shl, 6 shr, 7 xor.
- cmd_rd  input  2  destination register.
- cmd_ra  input  2  source register for ALU a.
- cmd_rb  input  2  source register for ALU b.
- cmd_use_imm  input  1  1 selects cmd_imm as ALU b instead of reg[rb].
- cmd_imm  input  8  immediate operand.
- cmd_no_wb  input  1  1 updates flags only (compare/test); no register write.
- alu_a  output  8  registered ALU operand a.
- alu_b  output  8  registered ALU operand b.
- alu_opSel  output  3  registered ALU opcode.
- alu_result  input  8  ALU result.
- alu_zeroF, alu_carryF, alu_negativeF, alu_overflowF  input  1 each  ALU flags.
- flags  output  4  {zero, carry, negative, overflow} of the last completed command.
- done  output  1  one-cycle pulse when a command completes writeback.
- wb_data  output  8  result of the completed command; valid while done=1.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; all registers and outputs 0: reg file, alu_a/b/opSel, flags, done, wb_data.
  - cmd_ready=0 while rst_n is low, 1 in IDLE after reset.
- FSM IDLE -> EXEC -> WB -> IDLE; throughput is one command per 3 cycles.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, register alu_a=reg[ra], alu_b = use_imm ? imm : reg[rb], alu_opSel=op.
  - Latch rd and no_wb, then go to EXEC.
- EXEC:
  - cmd_ready=0; ALU settles combinationally.
  - At the clock edge, capture alu_result into wb_data and the four ALU flags into a pending register; go to WB.
- WB:
  - cmd_ready=0; done=1 for exactly this cycle.
  - At the clock edge, flags<=pending flags, and reg[rd]<=wb_data unless no_wb. Go to IDLE.
- Flags:
  - Update only on WB edges and hold otherwise.
  - Carry on sub means borrow (a<b unsigned).
  - For ops 2-7, carry and overflow are 0, as the ALU produces them.
- Operand reads in IDLE see every completed write, because the WB write lands before the next IDLE accept. No forwarding is needed.
- cmd_* fields are sampled only on the accept cycle; changes while cmd_ready=0 are ignored.
- cmd_valid may stay high continuously; a new command is accepted every third cycle.
- ra=rb=rd is legal: operands read the old value and the result overwrites it.
- Reset asserted mid-command aborts it: no write, flags cleared, state IDLE.
- Register file is internal; there is no external read port besides wb_data/flags.

Decomposition:
- Shared package holds:
  - opcode constants OP_ADD..OP_XOR (0..7);
  - FSM state encoding (IDLE=0, EXEC=1, WB=2);
  - flag bit indices FLAG_Z=3, FLAG_C=2, FLAG_N=1, FLAG_V=0.
- One natural sub-module: regfile_4x8 (async read of two ports, one synchronous write port, async active-low clear).
- The ALU stays a separate instance at the top level; the bench connects it.

Test Plan:
- Load 0x7F into r0 (pass a with ra from a pre-loaded reg via op 4 path, or imm seeded by xor r0,r0 then or imm), then add r1=r0+imm 0x01:
  - wb_data=0x80, flags Z=0 C=0 N=1 V=1, r1=0x80, done one cycle, 3 cycles after accept.
- sub r2 = r3(0x00) - imm 0x01:
  - wb_data=0xFF, flags Z=0 C=1 N=1 V=0.
- Compare: sub with cmd_no_wb=1, r0=0x55 vs imm 0x55:
  - flags Z=1 C=0 N=0 V=0; r0 stays 0x55 (no write).
- Back-to-back dependency with cmd_valid held high: add r1=r1+imm 1 issued 4 times from r1=0xFE:
  - results 0xFF, 0x00 (Z=1, C=1), 0x01, 0x02;
  - accepts exactly every 3 cycles; cmd_ready low in EXEC/WB.
- Shift: shl r2=0x81 -> 0x02 with C=0 V=0; then shr 0x02 -> 0x01.
- Reset pulse asserted during EXEC:
  - outputs and reg file read 0 immediately (async);
  - no done pulse; cmd_ready=1 one cycle after rst_n rises.

Source files
------------

// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operation sequencer.
// Contents:
//   alu_op_e     : ALU opSel encoding (add, sub, and, or, pass a, shl, shr, xor)
//   seq_state_e  : sequencer FSM state encoding (IDLE, EXEC, WB)
//   FLAG_*       : bit positions of {zero, carry, negative, overflow} in the
//                  4-bit flag vector
package alu_op_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_PSA = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_XOR = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } seq_state_e;

  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/alu_op_sequencer_regfile_4x8.sv
// Small register file for the ALU sequencer.
// Two asynchronous read ports, one synchronous write port and an
// asynchronous active-low clear of every entry.
// Ports:
//   clk, rst_n            : clock, async active-low clear
//   rd_addr_a / rd_data_a : read port A
//   rd_addr_b / rd_data_b : read port B
//   wr_en, wr_addr, wr_data : write port, written on the rising clock edge
module regfile_4x8 #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NREGS  = 4,
  localparam int unsigned AW    = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [AW-1:0]     rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem_q [NREGS];
  logic [DATA_W-1:0] mem_d [NREGS];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rd_data_a = mem_q[rd_addr_a];
  assign rd_data_b = mem_q[rd_addr_b];

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle control/register stage around an external 8-bit combinational ALU.
// One command is accepted per valid/ready handshake; operands come from the
// internal register file (or an immediate for b), the ALU result is captured,
// written back to the register file and the flags are held in a sticky register.
// Sequence: IDLE (accept) -> EXEC (ALU settles, capture) -> WB (done, write).
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   cmd_*             : command handshake and fields (sampled on accept only)
//   alu_a/alu_b/alu_opSel : registered ALU inputs
//   alu_result, alu_*F    : ALU outputs
//   flags             : {Z,C,N,V} of the last completed command
//   done, wb_data     : completion pulse and its result
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NREGS  = 4,
  localparam int unsigned AW    = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [AW-1:0]     cmd_rd,
  input  logic [AW-1:0]     cmd_ra,
  input  logic [AW-1:0]     cmd_rb,
  input  logic              cmd_use_imm,
  input  logic [DATA_W-1:0] cmd_imm,
  input  logic              cmd_no_wb,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_opSel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zeroF,
  input  logic              alu_carryF,
  input  logic              alu_negativeF,
  input  logic              alu_overflowF,
  output logic [3:0]        flags,
  output logic              done,
  output logic [DATA_W-1:0] wb_data
);

  seq_state_e        state_q, state_d;
  logic              started_q, started_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  alu_op_e           alu_op_q, alu_op_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic              no_wb_q, no_wb_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [3:0]        pend_flags_q, pend_flags_d;
  logic [3:0]        flags_q, flags_d;

  logic [DATA_W-1:0] rf_data_a;
  logic [DATA_W-1:0] rf_data_b;
  logic              rf_we;

  regfile_4x8 #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr_a (cmd_ra),
    .rd_data_a (rf_data_a),
    .rd_addr_b (cmd_rb),
    .rd_data_b (rf_data_b),
    .wr_en     (rf_we),
    .wr_addr   (rd_q),
    .wr_data   (wb_data_q)
  );

  always_comb begin
    state_d      = state_q;
    started_d    = 1'b1;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rd_d         = rd_q;
    no_wb_d      = no_wb_q;
    wb_data_d    = wb_data_q;
    pend_flags_d = pend_flags_q;
    flags_d      = flags_q;
    rf_we        = 1'b0;
    // started_q holds ready low during reset and for the first edge after it,
    // since state_q already reads IDLE while rst_n is low.
    cmd_ready    = started_q && (state_q == ST_IDLE);
    done         = (state_q == ST_WB);

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          alu_a_d  = rf_data_a;
          alu_b_d  = cmd_use_imm ? cmd_imm : rf_data_b;
          alu_op_d = alu_op_e'(cmd_op);
          rd_d     = cmd_rd;
          no_wb_d  = cmd_no_wb;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        wb_data_d            = alu_result;
        pend_flags_d[FLAG_Z] = alu_zeroF;
        pend_flags_d[FLAG_C] = alu_carryF;
        pend_flags_d[FLAG_N] = alu_negativeF;
        pend_flags_d[FLAG_V] = alu_overflowF;
        state_d              = ST_WB;
      end
      ST_WB: begin
        flags_d = pend_flags_q;
        rf_we   = !no_wb_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      started_q    <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= OP_ADD;
      rd_q         <= '0;
      no_wb_q      <= 1'b0;
      wb_data_q    <= '0;
      pend_flags_q <= '0;
      flags_q      <= '0;
    end else begin
      state_q      <= state_d;
      started_q    <= started_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rd_q         <= rd_d;
      no_wb_q      <= no_wb_d;
      wb_data_q    <= wb_data_d;
      pend_flags_q <= pend_flags_d;
      flags_q      <= flags_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_opSel = alu_op_q;
  assign wb_data   = wb_data_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a behavioural 8-bit ALU.
module tb_alu_op_sequencer;
  import alu_op_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [1:0] cmd_rd, cmd_ra, cmd_rb;
  logic       cmd_use_imm;
  logic [7:0] cmd_imm;
  logic       cmd_no_wb;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_opSel;
  logic [7:0] alu_result;
  logic       alu_zeroF, alu_carryF, alu_negativeF, alu_overflowF;
  logic [3:0] flags;
  logic       done;
  logic [7:0] wb_data;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_op_sequencer #(.DATA_W(8), .NREGS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
    .cmd_use_imm(cmd_use_imm), .cmd_imm(cmd_imm), .cmd_no_wb(cmd_no_wb),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opSel(alu_opSel),
    .alu_result(alu_result), .alu_zeroF(alu_zeroF), .alu_carryF(alu_carryF),
    .alu_negativeF(alu_negativeF), .alu_overflowF(alu_overflowF),
    .flags(flags), .done(done), .wb_data(wb_data)
  );

  // Behavioural ALU: carry is carry-out on add, borrow on sub, 0 otherwise;
  // overflow is signed overflow on add/sub, 0 otherwise; shifts are by one.
  logic [8:0] alu_w;
  always_comb begin
    alu_w         = '0;
    alu_result    = '0;
    alu_carryF    = 1'b0;
    alu_overflowF = 1'b0;
    case (alu_opSel)
      3'd0: begin
        alu_w         = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result    = alu_w[7:0];
        alu_carryF    = alu_w[8];
        alu_overflowF = (alu_a[7] == alu_b[7]) && (alu_result[7] != alu_a[7]);
      end
      3'd1: begin
        alu_result    = alu_a - alu_b;
        alu_carryF    = (alu_a < alu_b);
        alu_overflowF = (alu_a[7] != alu_b[7]) && (alu_result[7] != alu_a[7]);
      end
      3'd2: alu_result = alu_a & alu_b;
      3'd3: alu_result = alu_a | alu_b;
      3'd4: alu_result = alu_a;
      3'd5: alu_result = {alu_a[6:0], 1'b0};
      3'd6: alu_result = {1'b0, alu_a[7:1]};
      default: alu_result = alu_a ^ alu_b;
    endcase
    alu_zeroF     = (alu_result == 8'h00);
    alu_negativeF = alu_result[7];
  end

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [1:0] rd, ra, rb;
    logic       use_imm;
    logic [7:0] imm;
    logic       no_wb;
    logic [7:0] exp_wb;
    logic [3:0] exp_flags;  // {Z,C,N,V}
  } vec_t;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("ready_timeout", 8'(cmd_ready), 8'h01);
  endtask

  task automatic drive(input vec_t v);
    cmd_op      = v.op;
    cmd_rd      = v.rd;
    cmd_ra      = v.ra;
    cmd_rb      = v.rb;
    cmd_use_imm = v.use_imm;
    cmd_imm     = v.imm;
    cmd_no_wb   = v.no_wb;
    cmd_valid   = 1'b1;
  endtask

  task automatic run_cmd(input vec_t v);
    wait_ready();
    drive(v);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk({v.name, "_exec_ready"}, 8'(cmd_ready), 8'h00);
    chk({v.name, "_exec_done"}, 8'(done), 8'h00);
    @(posedge clk); #1;
    chk({v.name, "_wb_done"}, 8'(done), 8'h01);
    chk({v.name, "_wb_data"}, wb_data, v.exp_wb);
    @(posedge clk); #1;
    chk({v.name, "_done_drop"}, 8'(done), 8'h00);
    chk({v.name, "_flags"}, 8'(flags), 8'(v.exp_flags));
    chk({v.name, "_idle_ready"}, 8'(cmd_ready), 8'h01);
  endtask

  vec_t vecs[14];
  vec_t pv[3];
  vec_t b2b;
  logic [7:0] b2b_exp_wb[4];
  logic [3:0] b2b_exp_fl[4];

  initial begin
    //            name        op  rd  ra  rb  imm?  imm    nowb  wb     ZCNV
    vecs[0]  = '{"xor_clr",   3'd7, 2'd0, 2'd0, 2'd0, 1'b0, 8'h00, 1'b0, 8'h00, 4'b1000};
    vecs[1]  = '{"or_7f",     3'd3, 2'd0, 2'd0, 2'd0, 1'b1, 8'h7F, 1'b0, 8'h7F, 4'b0000};
    vecs[2]  = '{"add_ovf",   3'd0, 2'd1, 2'd0, 2'd0, 1'b1, 8'h01, 1'b0, 8'h80, 4'b0011};
    vecs[3]  = '{"sub_borrow",3'd1, 2'd2, 2'd3, 2'd0, 1'b1, 8'h01, 1'b0, 8'hFF, 4'b0110};
    vecs[4]  = '{"pass_r1",   3'd4, 2'd3, 2'd1, 2'd0, 1'b0, 8'h00, 1'b1, 8'h80, 4'b0010};
    vecs[5]  = '{"or_55",     3'd3, 2'd0, 2'd3, 2'd0, 1'b1, 8'h55, 1'b0, 8'h55, 4'b0000};
    vecs[6]  = '{"cmp_eq",    3'd1, 2'd0, 2'd0, 2'd0, 1'b1, 8'h55, 1'b1, 8'h00, 4'b1000};
    vecs[7]  = '{"pass_r0",   3'd4, 2'd3, 2'd0, 2'd0, 1'b0, 8'h00, 1'b1, 8'h55, 4'b0000};
    vecs[8]  = '{"or_81",     3'd3, 2'd2, 2'd3, 2'd0, 1'b1, 8'h81, 1'b0, 8'h81, 4'b0010};
    vecs[9]  = '{"shl",       3'd5, 2'd2, 2'd2, 2'd0, 1'b0, 8'h00, 1'b0, 8'h02, 4'b0000};
    vecs[10] = '{"shr",       3'd6, 2'd2, 2'd2, 2'd0, 1'b0, 8'h00, 1'b0, 8'h01, 4'b0000};
    vecs[11] = '{"xor_fe",    3'd7, 2'd1, 2'd3, 2'd0, 1'b1, 8'hFE, 1'b0, 8'hFE, 4'b0010};
    vecs[12] = '{"and_test",  3'd2, 2'd0, 2'd1, 2'd0, 1'b1, 8'h0F, 1'b1, 8'h0E, 4'b0000};
    vecs[13] = '{"add_same",  3'd0, 2'd2, 2'd2, 2'd2, 1'b0, 8'h00, 1'b0, 8'h02, 4'b0000};

    b2b = '{"b2b", 3'd0, 2'd1, 2'd1, 2'd0, 1'b1, 8'h01, 1'b0, 8'h00, 4'b0000};
    b2b_exp_wb[0] = 8'hFF; b2b_exp_fl[0] = 4'b0010;
    b2b_exp_wb[1] = 8'h00; b2b_exp_fl[1] = 4'b1100;
    b2b_exp_wb[2] = 8'h01; b2b_exp_fl[2] = 4'b0000;
    b2b_exp_wb[3] = 8'h02; b2b_exp_fl[3] = 4'b0000;

    pv[0] = '{"rst_r0", 3'd4, 2'd3, 2'd0, 2'd0, 1'b0, 8'h00, 1'b1, 8'h00, 4'b1000};
    pv[1] = '{"rst_r1", 3'd4, 2'd3, 2'd1, 2'd0, 1'b0, 8'h00, 1'b1, 8'h00, 4'b1000};
    pv[2] = '{"rst_r2", 3'd4, 2'd3, 2'd2, 2'd0, 1'b0, 8'h00, 1'b1, 8'h00, 4'b1000};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_ra = '0;
    cmd_rb = '0; cmd_use_imm = 1'b0; cmd_imm = '0; cmd_no_wb = 1'b0;

    // Reset state
    #1;
    chk("rst_ready", 8'(cmd_ready), 8'h00);
    chk("rst_done", 8'(done), 8'h00);
    chk("rst_flags", 8'(flags), 8'h00);
    chk("rst_wb", wb_data, 8'h00);
    chk("rst_alu_a", alu_a, 8'h00);
    chk("rst_opsel", 8'(alu_opSel), 8'h00);
    repeat (2) @(posedge clk);
    #1 chk("rst_ready_held", 8'(cmd_ready), 8'h00);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("post_rst_ready_early", 8'(cmd_ready), 8'h00);
    @(posedge clk); #1;
    chk("post_rst_ready", 8'(cmd_ready), 8'h01);

    for (int i = 0; i < 14; i++) run_cmd(vecs[i]);

    // Back-to-back with cmd_valid held high: r1 = r1 + 1 from 0xFE.
    begin
      int last_acc = 0;
      wait_ready();
      drive(b2b);
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("b2b%0d_ready", k), 8'(cmd_ready), 8'h01);
        @(posedge clk);
        if (k > 0) chk($sformatf("b2b%0d_gap", k), 8'(cyc - last_acc), 8'd3);
        last_acc = cyc;
        #1;
        chk($sformatf("b2b%0d_exec_ready", k), 8'(cmd_ready), 8'h00);
        if (k == 1) begin
          cmd_op = 3'd7; cmd_imm = 8'h40; cmd_rd = 2'd3;  // must be ignored
        end
        if (k == 3) cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("b2b%0d_done", k), 8'(done), 8'h01);
        chk($sformatf("b2b%0d_wb_ready", k), 8'(cmd_ready), 8'h00);
        chk($sformatf("b2b%0d_wb", k), wb_data, b2b_exp_wb[k]);
        if (k == 1) drive(b2b);
        @(posedge clk); #1;
        chk($sformatf("b2b%0d_done_drop", k), 8'(done), 8'h00);
        chk($sformatf("b2b%0d_flags", k), 8'(flags), 8'(b2b_exp_fl[k]));
        @(negedge clk);
      end
    end

    // Reset pulse during EXEC of add r0 = r0 + 1.
    wait_ready();
    drive('{"rst_add", 3'd0, 2'd0, 2'd0, 2'd0, 1'b1, 8'h01, 1'b0, 8'h56, 4'b0000});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_alu_a", alu_a, 8'h00);
    chk("mid_rst_alu_b", alu_b, 8'h00);
    chk("mid_rst_opsel", 8'(alu_opSel), 8'h00);
    chk("mid_rst_flags", 8'(flags), 8'h00);
    chk("mid_rst_wb", wb_data, 8'h00);
    chk("mid_rst_ready", 8'(cmd_ready), 8'h00);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk($sformatf("mid_rst_done%0d", k), 8'(done), 8'h00);
    end
    @(negedge clk); rst_n = 1'b1;
    #1 chk("mid_rst_ready_early", 8'(cmd_ready), 8'h00);
    @(posedge clk); #1;
    chk("mid_rst_done_after", 8'(done), 8'h00);
    chk("mid_rst_ready_after", 8'(cmd_ready), 8'h01);
    for (int i = 0; i < 3; i++) run_cmd(pv[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
